// File: rtl/alu_mul_seq_if.sv
// Bus between the execute stage, the multiply sequencer and the shared ALU.
// Groups the datapath operands, the multiply request/result and the ALU drive.
interface alu_mul_seq_if #(
    parameter int size = 32
);
    // Handshake: START is a request that the sequencer samples only while
    // BUSY is low (IDLE). A START seen while BUSY is high, including the FIN
    // cycle, is dropped, not queued. BUSY (== STALL) rises on the edge that
    // accepts START and stays high through CALC and FIN. DONE is a single-cycle
    // pulse in the FIN cycle, and PRODUCTO is valid from that cycle on. It holds
    // that value until a later multiply finishes or reset clears it.
    logic [size-1:0] X_dp;
    logic [size-1:0] Y_dp;
    logic [3:0]      CONTROL_dp;
    logic            START;
    logic [size-1:0] OP_A;
    logic [size-1:0] OP_B;
    logic [size-1:0] RESULTADO;
    logic [size-1:0] X;
    logic [size-1:0] Y;
    logic [3:0]      CONTROL;
    logic            BUSY;
    logic            STALL;
    logic            DONE;
    logic [size-1:0] PRODUCTO;

    // Sequencer side: consumes the datapath and ALU result, drives the ALU.
    modport slave (
        input  X_dp, Y_dp, CONTROL_dp, START, OP_A, OP_B, RESULTADO,
        output X, Y, CONTROL, BUSY, STALL, DONE, PRODUCTO
    );

    // Environment side: execute stage plus the ALU instance.
    modport master (
        output X_dp, Y_dp, CONTROL_dp, START, OP_A, OP_B, RESULTADO,
        input  X, Y, CONTROL, BUSY, STALL, DONE, PRODUCTO
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that borrows the execute-stage ALU.
// In IDLE the ALU inputs pass straight through from the datapath. During a
// multiply the sequencer issues one ADD per iteration and stalls the datapath.
// Optional macro MUL_EARLY_EXIT_EN: leave CALC as soon as the remaining
// multiplier bits are all zero, instead of always running size iterations.
module alu_mul_seq #(
    parameter int size = 32
) (
    input  logic       CLK,
    input  logic       RST_n,
    alu_mul_seq_if.slave bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(size + 1);
    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [size-1:0] acc;
    logic [size-1:0] mcand;
    logic [size-1:0] mplier;
    logic [size-1:0] acc_nxt;
    logic [size-1:0] prod;
    logic [CW-1:0]   count;
    logic            last_iter;
    logic [size-1:0] x_mux;
    logic [size-1:0] y_mux;
    logic [3:0]      ctl_mux;
    logic            busy;
    logic            done;

    // The ALU computes acc + mcand this cycle; keep it only if the multiplier bit is set.
    assign acc_nxt = mplier[0] ? bus.RESULTADO : acc;

`ifdef MUL_EARLY_EXIT_EN
    // Stop after this iteration if no multiplier bits remain above bit 0.
    assign last_iter = (count == CW'(size - 1)) || ((mplier >> 1) == '0);
`else
    // Fixed-length multiply: exactly size iterations.
    assign last_iter = (count == CW'(size - 1));
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, ALU input mux and status outputs.
    always_comb begin
        state_nxt = state;
        x_mux     = bus.X_dp;
        y_mux     = bus.Y_dp;
        ctl_mux   = bus.CONTROL_dp;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy    = 1'b1;
                x_mux   = acc;
                y_mux   = mcand;
                ctl_mux = ALU_ADD;
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                x_mux     = acc;
                y_mux     = '0;
                ctl_mux   = ALU_ADD;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Multiply datapath: operand latch on accept, one shift-add step per CALC cycle.
    // The product register is loaded on the last step so it is valid while DONE is high.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            prod   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        acc    <= '0;
                        mcand  <= bus.OP_A;
                        mplier <= bus.OP_B;
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_iter) begin
                        prod <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.X        = x_mux;
    assign bus.Y        = y_mux;
    assign bus.CONTROL  = ctl_mux;
    assign bus.BUSY     = busy;
    assign bus.STALL    = busy;
    assign bus.DONE     = done;
    assign bus.PRODUCTO = prod;
    assign state_dbg    = state;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: ALU model, directed and random multiplies.
module tb_alu_mul_seq;
    logic       CLK;
    logic       RST_n;
    logic [1:0] state_dbg;
    int         total;
    int         bad;

    alu_mul_seq_if #(.size(32)) bus ();

    alu_mul_seq #(.size(32)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and the shared ALU (ADD, SUB, otherwise XOR).
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        case (bus.CONTROL)
            4'b0000: bus.RESULTADO = bus.X + bus.Y;
            4'b0111: bus.RESULTADO = bus.X - bus.Y;
            default: bus.RESULTADO = bus.X ^ bus.Y;
        endcase
    end

    // Expected number of CALC cycles for a given multiplier.
    function automatic int exp_calc(input logic [31:0] b);
        int hi;
        hi = 0;
`ifdef MUL_EARLY_EXIT_EN
        for (int j = 0; j < 32; j++) begin
            if (b[j]) hi = j;
        end
        return hi + 1;
`else
        return 32 + hi;
`endif
    endfunction

    // One multiply. poke: loop index at which a 9*9 START is injected for one
    // cycle (negative = none). tail: idle cycles checked after DONE.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int poke, input int tail, input string tag);
        logic [31:0] exp;
        int n;
        int done_at;
        exp = a * b;
        n = exp_calc(b);
        done_at = -1;
        bus.OP_A = a;
        bus.OP_B = b;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (done_at < 0) begin
                if (bus.DONE === 1'b1) begin
                    done_at = i;
                    total++;
                    if (i !== n) begin
                        bad++;
                        $display("FAIL %s latency: done after %0d calc cycles, want %0d", tag, i, n);
                    end
                    total++;
                    if (bus.PRODUCTO !== exp) begin
                        bad++;
                        $display("FAIL %s product: got %h want %h (a=%h b=%h)", tag, bus.PRODUCTO, exp, a, b);
                    end
                    total++;
                    if (bus.BUSY !== 1'b1 || bus.STALL !== 1'b1) begin
                        bad++;
                        $display("FAIL %s busy_fin: busy=%b stall=%b want 1/1", tag, bus.BUSY, bus.STALL);
                    end
                end else begin
                    total++;
                    if (bus.BUSY !== 1'b1 || bus.STALL !== 1'b1 || bus.CONTROL !== 4'b0000) begin
                        bad++;
                        $display("FAIL %s calc cycle %0d: busy=%b stall=%b ctl=%b want 1/1/0000",
                                 tag, i, bus.BUSY, bus.STALL, bus.CONTROL);
                    end
                end
            end else begin
                total++;
                if (bus.BUSY !== 1'b0 || bus.STALL !== 1'b0 || bus.DONE !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle_after: busy=%b stall=%b done=%b want 0/0/0",
                             tag, bus.BUSY, bus.STALL, bus.DONE);
                end
                if (i == done_at + 1) begin
                    total++;
                    if (bus.PRODUCTO !== exp) begin
                        bad++;
                        $display("FAIL %s product_hold: got %h want %h", tag, bus.PRODUCTO, exp);
                    end
                end
            end
            if (i == poke) begin
                bus.START = 1'b1;
                bus.OP_A = 32'd9;
                bus.OP_B = 32'd9;
            end else if (i == poke + 1) begin
                bus.START = 1'b0;
            end
            if (done_at >= 0 && i >= done_at + tail) break;
        end
        if (done_at < 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no DONE within 200 cycles, want after %0d", tag, n);
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        bus.START = 1'b0;
        bus.OP_A = '0;
        bus.OP_B = '0;
        bus.X_dp = 32'd1;
        bus.Y_dp = 32'd2;
        bus.CONTROL_dp = 4'b0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (bus.BUSY !== 1'b0 || bus.STALL !== 1'b0 || bus.DONE !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: busy=%b stall=%b done=%b want 0/0/0", bus.BUSY, bus.STALL, bus.DONE);
        end
        total++;
        if (bus.PRODUCTO !== 32'd0) begin
            bad++;
            $display("FAIL reset_product: got %h want 0", bus.PRODUCTO);
        end
        RST_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_idle_pass();
        logic [31:0] xr;
        logic [31:0] yr;
        bus.X_dp = 32'd22;
        bus.Y_dp = 32'd5;
        bus.CONTROL_dp = 4'b0111;
        #1;
        total++;
        if (bus.X !== 32'd22 || bus.Y !== 32'd5 || bus.CONTROL !== 4'b0111) begin
            bad++;
            $display("FAIL idle_pass: x=%0d y=%0d ctl=%b want 22/5/0111", bus.X, bus.Y, bus.CONTROL);
        end
        total++;
        if (bus.RESULTADO !== 32'd17 || bus.STALL !== 1'b0) begin
            bad++;
            $display("FAIL idle_result: res=%0d stall=%b want 17/0", bus.RESULTADO, bus.STALL);
        end
        for (int k = 0; k < 4; k++) begin
            xr = $urandom;
            yr = $urandom;
            bus.X_dp = xr;
            bus.Y_dp = yr;
            bus.CONTROL_dp = 4'($urandom_range(0, 15));
            @(negedge CLK);
            total++;
            if (bus.X !== xr || bus.Y !== yr || bus.CONTROL !== bus.CONTROL_dp || bus.BUSY !== 1'b0) begin
                bad++;
                $display("FAIL idle_pass_rand: x=%h y=%h ctl=%b busy=%b want %h/%h/%b/0",
                         bus.X, bus.Y, bus.CONTROL, bus.BUSY, xr, yr, bus.CONTROL_dp);
            end
        end
    endtask

    task automatic test_basic();
        run_mul(32'd7, 32'd6, -10, 2, "mul_7x6");
        run_mul(32'hFFFF_FFFF, 32'd2, -10, 2, "mul_ffffffff_x2");
        run_mul(-32'sd3, 32'd5, -10, 2, "mul_m3x5");
    endtask

    task automatic test_ignore_start();
        int fin_at;
`ifdef MUL_EARLY_EXIT_EN
        run_mul(32'd7, 32'd6, 1, 3, "ignore_busy");
`else
        run_mul(32'd7, 32'd6, 5, 3, "ignore_busy");
`endif
        fin_at = exp_calc(32'd6);
        run_mul(32'd7, 32'd6, fin_at, 3, "ignore_fin");
    endtask

    task automatic test_reset_abort();
        int abort_at;
`ifdef MUL_EARLY_EXIT_EN
        abort_at = 1;
`else
        abort_at = 10;
`endif
        bus.OP_A = 32'd7;
        bus.OP_B = 32'd6;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        for (int i = 0; i <= abort_at; i++) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        total++;
        if (bus.BUSY !== 1'b0 || bus.STALL !== 1'b0 || bus.DONE !== 1'b0) begin
            bad++;
            $display("FAIL abort_status: busy=%b stall=%b done=%b want 0/0/0", bus.BUSY, bus.STALL, bus.DONE);
        end
        total++;
        if (bus.PRODUCTO !== 32'd0) begin
            bad++;
            $display("FAIL abort_product: got %h want 0", bus.PRODUCTO);
        end
        @(negedge CLK);
        RST_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total++;
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet: done=%b busy=%b want 0/0", bus.DONE, bus.BUSY);
            end
        end
        run_mul(32'd3, 32'd4, -10, 2, "after_abort");
    endtask

    task automatic test_early_exit();
        run_mul(32'd3, 32'd1, -10, 2, "exit_3x1");
        run_mul(32'd5, 32'd0, -10, 2, "exit_5x0");
        run_mul(32'd0, 32'h8000_0000, -10, 2, "exit_0xmsb");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            run_mul($urandom, $urandom, -10, 1, "b2b");
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            b = $urandom;
            b = b >> $urandom_range(0, 31);
            run_mul(a, b, -10, $urandom_range(1, 3), "rand");
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_idle_pass();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_early_exit();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the run wedges somewhere unexpected.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
